// File: rtl/mips16_pkg.sv
// -----------------------------------------------------------------------------
// mips16_pkg
// Shared definitions for the MIPS16 data-side store buffer.
//   DATA_W          : data and address width
//   WIDX_HI/WIDX_LO : bounds of the memory word index inside a byte address
//   sb_entry_t      : one pending store {addr, data}
// -----------------------------------------------------------------------------
package mips16_pkg;

  localparam int DATA_W  = 16;
  localparam int WIDX_HI = 9;
  localparam int WIDX_LO = 2;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

  // True when two byte addresses select the same memory word.
  function automatic logic same_word(input logic [DATA_W-1:0] a,
                                     input logic [DATA_W-1:0] b);
    return a[WIDX_HI:WIDX_LO] == b[WIDX_HI:WIDX_LO];
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// -----------------------------------------------------------------------------
// sb_fifo
// Circular storage for pending stores plus write/read pointers and occupancy.
// Entry storage is never reset; an entry is live only while it lies inside the
// [rd_ptr, rd_ptr+count) window.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   push_i         : write push_entry_i at wr_ptr (ignored when full)
//   push_entry_i   : store to enqueue
//   pop_i          : retire the head entry (ignored when empty)
//   entries_o      : raw storage, indexed by physical slot
//   rd_ptr_o       : physical slot of the oldest entry
//   count_o        : number of live entries (0..DEPTH)
//   head_o         : oldest entry
// -----------------------------------------------------------------------------
module sb_fifo
  import mips16_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  sb_entry_t              push_entry_i,
  input  logic                   pop_i,
  output sb_entry_t [DEPTH-1:0]  entries_o,
  output logic      [PTR_W-1:0]  rd_ptr_o,
  output logic      [CNT_W-1:0]  count_o,
  output sb_entry_t              head_o
);

  sb_entry_t [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q,  count_d;
  logic                  do_push_s;
  logic                  do_pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Local guards keep count inside 0..DEPTH whatever the caller requests.
  assign do_push_s = push_i && (count_q != CNT_W'(DEPTH));
  assign do_pop_s  = pop_i  && (count_q != CNT_W'(0));

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = do_push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, deliberately without reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

  assign entries_o = mem_q;
  assign rd_ptr_o  = rd_ptr_q;
  assign count_o   = count_q;
  assign head_o    = mem_q[rd_ptr_q];

endmodule

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
// Pending-store buffer between the MEM stage and a single-ported data memory.
// Stores are queued and drained in order; loads share the memory port.
// Port priority each cycle: drain if full, load if requested, drain if not
// empty, idle. A load whose word index ([9:2]) matches a pending store is a hit.
// Build option STORE_FWD_EN:
//   defined   : a hit returns the youngest matching store's data directly and
//               the port is used for a drain in the same cycle.
//   undefined : a hit stalls the load and forces drains until no entry matches,
//               then the load is read from memory.
// Ports:
//   clk, rst_n                        : clock, asynchronous active-low reset
//   st_valid/st_addr/st_data/st_ready : store request / accept
//   ld_valid/ld_addr/ld_ready/ld_data : load request / completion and data
//   mem_access_addr, mem_write_data, mem_write_en, mem_read, mem_read_data
//                                     : data-memory port
//   empty, full                       : occupancy flags
// DATA_W must equal mips16_pkg::DATA_W since entries use sb_entry_t.
// -----------------------------------------------------------------------------
module store_buffer
  import mips16_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = mips16_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  input  logic [DATA_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_ready,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_addr,
  output logic              ld_ready,
  output logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  sb_entry_t [DEPTH-1:0] entries_s;
  sb_entry_t             head_s;
  sb_entry_t             push_entry_s;
  logic [PTR_W-1:0]      rd_ptr_s;
  logic [CNT_W-1:0]      count_s;
  logic                  push_s;
  logic                  drain_s;
  logic                  hit_s;
  logic [DATA_W-1:0]     fwd_data_s;

  assign full         = (count_s == CNT_W'(DEPTH));
  assign empty        = (count_s == CNT_W'(0));
  assign st_ready     = !full;
  assign push_s       = st_valid && st_ready;
  assign push_entry_s = '{addr: st_addr, data: st_data};

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push_s),
    .push_entry_i (push_entry_s),
    .pop_i        (drain_s),
    .entries_o    (entries_s),
    .rd_ptr_o     (rd_ptr_s),
    .count_o      (count_s),
    .head_o       (head_s)
  );

  // Hit search: walk live entries oldest to youngest so the last match wins.
  always_comb begin : hit_search
    logic [PTR_W-1:0] idx;
    hit_s      = 1'b0;
    fwd_data_s = '0;
    idx        = rd_ptr_s;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_s + PTR_W'(k);
      if ((CNT_W'(k) < count_s) && same_word(entries_s[idx].addr, ld_addr)) begin
        hit_s      = 1'b1;
        fwd_data_s = entries_s[idx].data;
      end else begin
        hit_s      = hit_s;
        fwd_data_s = fwd_data_s;
      end
    end
  end

  // Memory-port arbiter. Gating on rst_n drops the write enable the moment
  // reset asserts, so a drain in flight never commits.
  always_comb begin
    drain_s         = 1'b0;
    ld_ready        = 1'b0;
    ld_data         = '0;
    mem_read        = 1'b0;
    mem_write_en    = 1'b0;
    mem_access_addr = '0;
    mem_write_data  = '0;
    if (!rst_n) begin
      drain_s = 1'b0;
    end else if (full) begin
      drain_s = 1'b1;
    end else if (ld_valid) begin
      if (hit_s) begin
`ifdef STORE_FWD_EN
        ld_ready = 1'b1;
        ld_data  = fwd_data_s;
`endif
        // A hit implies a live entry, so draining is always legal here.
        drain_s  = 1'b1;
      end else begin
        mem_read        = 1'b1;
        mem_access_addr = ld_addr;
        ld_data         = mem_read_data;
        ld_ready        = 1'b1;
      end
    end else if (!empty) begin
      drain_s = 1'b1;
    end else begin
      drain_s = 1'b0;
    end

    if (drain_s) begin
      mem_write_en    = 1'b1;
      mem_access_addr = head_s.addr;
      mem_write_data  = head_s.data;
    end else begin
      mem_write_en    = mem_write_en;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic [15:0] st_addr;
  logic [15:0] st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [15:0] ld_addr;
  logic        ld_ready;
  logic [15:0] ld_data;
  logic [15:0] mem_access_addr;
  logic [15:0] mem_write_data;
  logic        mem_write_en;
  logic        mem_read;
  logic [15:0] mem_read_data;
  logic        empty;
  logic        full;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;
  wr_t exp_q[$];

  // Word-indexed memory model; unwritten words read as 0x1000 + index.
  logic [15:0] bmem [256];
  bit          bvld [256];

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4), .DATA_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .st_valid        (st_valid),
    .st_addr         (st_addr),
    .st_data         (st_data),
    .st_ready        (st_ready),
    .ld_valid        (ld_valid),
    .ld_addr         (ld_addr),
    .ld_ready        (ld_ready),
    .ld_data         (ld_data),
    .mem_access_addr (mem_access_addr),
    .mem_write_data  (mem_write_data),
    .mem_write_en    (mem_write_en),
    .mem_read        (mem_read),
    .mem_read_data   (mem_read_data),
    .empty           (empty),
    .full            (full)
  );

  assign mem_read_data = bvld[mem_access_addr[9:2]] ? bmem[mem_access_addr[9:2]]
                                                    : (16'h1000 + {8'h00, mem_access_addr[9:2]});

  always @(posedge clk) begin
    if (mem_write_en) begin
      bmem[mem_access_addr[9:2]] <= mem_write_data;
      bvld[mem_access_addr[9:2]] <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every presented drain must match the oldest expected store.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_write_en === 1'b1) begin
      chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("drain_addr", mem_access_addr, e.a);
        chk("drain_data", mem_write_data, e.d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sv, input logic [15:0] sa, input logic [15:0] sd,
                       input logic lv, input logic [15:0] la);
    st_valid = sv;
    st_addr  = sa;
    st_data  = sd;
    ld_valid = lv;
    ld_addr  = la;
  endtask

  task automatic push_exp(input logic [15:0] a, input logic [15:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_empty(input int budget);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (empty) begin
        seen = 1'b1;
        break;
      end
    end
    chk("drain_to_empty", seen, 1'b1);
    tick();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nxt;
    rst_n = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_st_ready", st_ready, 1'b1);
    chk("rst_mem_we", mem_write_en, 1'b0);
    chk("rst_ld_ready", ld_ready, 1'b0);
    tick();
    rst_n = 1'b1;

    // Single store drains on the next idle cycle.
    drive(1'b1, 16'h0010, 16'hABCD, 1'b0, 16'h0000);
    @(negedge clk);
    chk("t1_st_ready", st_ready, 1'b1);
    chk("t1_no_early_write", mem_write_en, 1'b0);
    push_exp(16'h0010, 16'hABCD);
    tick();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    @(negedge clk);
    chk("t1_we", mem_write_en, 1'b1);
    chk("t1_addr", mem_access_addr, 16'h0010);
    chk("t1_data", mem_write_data, 16'hABCD);
    tick();
    @(negedge clk);
    chk("t1_empty_after", empty, 1'b1);
    chk("t1_idle_addr", mem_access_addr, 16'h0000);
    chk("t1_idle_we", mem_write_en, 1'b0);
    tick();

    // Fill while loads hold the port, then full forces a drain and stalls the load.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'h0200 + 16'(4 * i), 16'(i + 1), 1'b1, 16'h0100);
      @(negedge clk);
      chk("t2_st_ready", st_ready, 1'b1);
      chk("t2_ld_ready", ld_ready, 1'b1);
      chk("t2_ld_data", ld_data, 16'h1040);
      chk("t2_mem_read", mem_read, 1'b1);
      push_exp(16'h0200 + 16'(4 * i), 16'(i + 1));
      tick();
    end
    drive(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0100);
    @(negedge clk);
    chk("t2_full", full, 1'b1);
    chk("t2_full_st_ready", st_ready, 1'b0);
    chk("t2_full_ld_stall", ld_ready, 1'b0);
    chk("t2_full_drain", mem_write_en, 1'b1);
    chk("t2_full_ld_data", ld_data, 16'h0000);
    tick();
    @(negedge clk);
    chk("t2_load_after", ld_ready, 1'b1);
    chk("t2_load_rd", mem_read, 1'b1);
    chk("t2_load_data", ld_data, 16'h1040);
    chk("t2_not_full", full, 1'b0);
    tick();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    wait_empty(10);

    // Two stores to the same word, then a load of that word.
    drive(1'b1, 16'h0020, 16'h1111, 1'b1, 16'h0100);
    @(negedge clk);
    push_exp(16'h0020, 16'h1111);
    tick();
    drive(1'b1, 16'h0020, 16'h2222, 1'b1, 16'h0100);
    @(negedge clk);
    push_exp(16'h0020, 16'h2222);
    tick();
    drive(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0020);
    @(negedge clk);
`ifdef STORE_FWD_EN
    chk("t3_fwd_ready", ld_ready, 1'b1);
    chk("t3_fwd_data", ld_data, 16'h2222);
    chk("t3_fwd_no_rd", mem_read, 1'b0);
    chk("t3_fwd_drain", mem_write_en, 1'b1);
    tick();
`else
    chk("t3_stall1", ld_ready, 1'b0);
    chk("t3_drain1", mem_write_en, 1'b1);
    chk("t3_no_rd1", mem_read, 1'b0);
    tick();
    @(negedge clk);
    chk("t3_stall2", ld_ready, 1'b0);
    chk("t3_drain2", mem_write_en, 1'b1);
    tick();
    @(negedge clk);
    chk("t3_ld_ready", ld_ready, 1'b1);
    chk("t3_mem_read", mem_read, 1'b1);
    chk("t3_ld_data", ld_data, 16'h2222);
    chk("t3_no_write", mem_write_en, 1'b0);
    tick();
`endif
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    wait_empty(10);

    // Load 0x0420 aliases a pending store to 0x0020 on the word index.
    drive(1'b1, 16'h0020, 16'h3333, 1'b1, 16'h0100);
    @(negedge clk);
    push_exp(16'h0020, 16'h3333);
    tick();
    drive(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0420);
    @(negedge clk);
`ifdef STORE_FWD_EN
    chk("t4_fwd_ready", ld_ready, 1'b1);
    chk("t4_fwd_data", ld_data, 16'h3333);
    chk("t4_fwd_no_rd", mem_read, 1'b0);
    tick();
`else
    chk("t4_alias_stall", ld_ready, 1'b0);
    chk("t4_alias_drain", mem_write_en, 1'b1);
    tick();
    @(negedge clk);
    chk("t4_ld_ready", ld_ready, 1'b1);
    chk("t4_ld_addr", mem_access_addr, 16'h0420);
    chk("t4_ld_data", ld_data, 16'h3333);
    tick();
`endif
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    wait_empty(10);

    // Full buffer with continuous stores: drains every cycle, pointers wrap.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'h0300 + 16'(4 * i), 16'hC000 + 16'(i), 1'b1, 16'h0100);
      @(negedge clk);
      push_exp(16'h0300 + 16'(4 * i), 16'hC000 + 16'(i));
      tick();
    end
    nxt = 4;
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 16'h0300 + 16'(4 * nxt), 16'hC000 + 16'(nxt), 1'b0, 16'h0000);
      @(negedge clk);
      chk("t5_drain_each", mem_write_en, 1'b1);
      chk("t5_st_ready", st_ready, (c != 0));
      chk("t5_full", full, (c == 0));
      if (c != 0) begin
        push_exp(16'h0300 + 16'(4 * nxt), 16'hC000 + 16'(nxt));
        nxt++;
      end
      tick();
    end
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    wait_empty(20);
    chk("t5_all_drained", exp_q.size(), 0);

    // Reset in the middle of a drain with three entries queued.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h0080 + 16'(4 * i), 16'hD000 + 16'(i), 1'b1, 16'h0100);
      @(negedge clk);
      push_exp(16'h0080 + 16'(4 * i), 16'hD000 + 16'(i));
      tick();
    end
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    @(negedge clk);
    chk("t6_draining", mem_write_en, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_we_drop", mem_write_en, 1'b0);
    chk("t6_empty", empty, 1'b1);
    chk("t6_st_ready", st_ready, 1'b1);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t6_no_later_write", mem_write_en, 1'b0);
    end
    chk("t6_no_partial_write", bvld[8'h20], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
